// File: rtl/alu_issue_seq.sv
// Issue sequencer for the ALU: buffers packed instruction words, drives the decoded
// fields onto the ALU for a settle window, then returns the sampled result over valid/ready.
module alu_issue_seq #(
    parameter int SETTLE = 2,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [13:0] instr,
    input  logic        flush,
    output logic        alu_mood,
    output logic [4:0]  alu_in1,
    output logic [4:0]  alu_in2,
    output logic [5:0]  alu_control,
    output logic        alu_reset,
    input  logic [31:0] alu_out,
    input  logic        alu_equality,
    input  logic        alu_balance,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_eq,
    output logic        res_bal,
    output logic        illegal,
    output logic        busy,
    output logic [15:0] issued_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [13:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [3:0]    cnt;
    logic [13:0]   head;
    logic          full, empty, push, pop;
    logic          head_illegal, issue, finish, release_res;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    // Ready is gated by reset so nothing is accepted while the block is held in reset.
    assign instr_ready  = reset && !full;
    assign push         = instr_valid && instr_ready && !flush;
    assign busy         = (state_q != IDLE) || !empty;
    assign head         = mem[rd_ptr];
    assign head_illegal = !head[13] && (head[12:10] > 3'd5);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        issue       = 1'b0;
        finish      = 1'b0;
        release_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!head_illegal) begin
                        issue   = 1'b1;
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            pop         = 1'b0;
            issue       = 1'b0;
            finish      = 1'b0;
            release_res = 1'b0;
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by count, so stale
    // entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= instr;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt          <= '0;
            alu_mood     <= 1'b0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_control  <= '0;
            alu_reset    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_eq       <= 1'b0;
            res_bal      <= 1'b0;
            illegal      <= 1'b0;
            issued_count <= '0;
        end else begin
            state_q   <= state_d;
            alu_reset <= flush;
            if (flush) begin
                alu_mood    <= 1'b0;
                alu_in1     <= '0;
                alu_in2     <= '0;
                alu_control <= '0;
                res_valid   <= 1'b0;
            end else begin
                if (pop && head_illegal) illegal <= 1'b1;
                if (issue) begin
                    alu_mood     <= head[13];
                    alu_control  <= head[13] ? 6'b000000 : (6'b000001 << head[12:10]);
                    alu_in1      <= head[9:5];
                    alu_in2      <= head[4:0];
                    cnt          <= 4'(SETTLE - 1);
                    issued_count <= issued_count + 16'd1;
                end
                if (state_q == DRIVE && !finish) cnt <= cnt - 4'd1;
                // Operand selects are left in place after the window; only mood/control drop.
                if (finish) begin
                    res_data    <= alu_out;
                    res_eq      <= alu_equality;
                    res_bal     <= alu_balance;
                    res_valid   <= 1'b1;
                    alu_control <= '0;
                    alu_mood    <= 1'b0;
                end
                if (release_res) res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: a behavioural ALU feeds back from the DUT's alu_*
// outputs, and expected results queue up at push time and are checked on each handshake.
module tb_alu_issue_seq;
    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        eq;
        logic        bal;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [13:0] instr;
    logic        flush;
    logic        alu_mood;
    logic [4:0]  alu_in1, alu_in2;
    logic [5:0]  alu_control;
    logic        alu_reset;
    logic [31:0] alu_out;
    logic        alu_equality, alu_balance;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_eq, res_bal;
    logic        illegal, busy;
    logic [15:0] issued_count;

    int   tests = 0;
    int   fails = 0;
    int   res_count = 0;
    int   exp_issued = 0;
    int   log_start;
    int   n;
    res_t sb[$];
    logic [5:0] ctrl_log[$];
    logic [5:0] ctrl_prev = '0;
    res_t alu_res;

    always #5 clk = ~clk;

    alu_issue_seq #(.SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .flush(flush), .alu_mood(alu_mood), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_control(alu_control), .alu_reset(alu_reset),
        .alu_out(alu_out), .alu_equality(alu_equality), .alu_balance(alu_balance),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_eq(res_eq), .res_bal(res_bal), .illegal(illegal), .busy(busy),
        .issued_count(issued_count)
    );

    function automatic res_t alu_model(input logic mood, input logic [5:0] ctrl,
                                       input logic [4:0] a, input logic [4:0] b);
        res_t r;
        r.data = {8'hA5, 7'h00, mood, ctrl, a, b};
        r.eq   = (a == b);
        r.bal  = ^{mood, ctrl, a, b};
        return r;
    endfunction

    assign alu_res      = alu_model(alu_mood, alu_control, alu_in1, alu_in2);
    assign alu_out      = alu_res.data;
    assign alu_equality = alu_res.eq;
    assign alu_balance  = alu_res.bal;

    function automatic logic [13:0] mk(input logic mood, input logic [2:0] op,
                                       input logic [4:0] a, input logic [4:0] b);
        return {mood, op, a, b};
    endfunction

    function automatic res_t expect_of(input logic [13:0] w);
        logic [5:0] ctrl;
        ctrl = w[13] ? 6'd0 : (6'd1 << w[12:10]);
        return alu_model(w[13], ctrl, w[9:5], w[4:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return 2 time units after the rising edge.
    task automatic tick();
        res_t exp;
        @(negedge clk);
        if (alu_control !== ctrl_prev) begin
            ctrl_log.push_back(alu_control);
            ctrl_prev = alu_control;
        end
        if (reset && res_valid && res_ready) begin
            res_count++;
            check("result_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("res_data", res_data, exp.data);
                check("res_eq", res_eq, exp.eq);
                check("res_bal", res_bal, exp.bal);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [13:0] w);
        int waited = 0;
        while (!instr_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("push_ready", instr_ready, 1);
        instr_valid = 1'b1;
        instr       = w;
        tick();
        instr_valid = 1'b0;
        if (w[13] || w[12:10] <= 3'd5) begin
            sb.push_back(expect_of(w));
            exp_issued++;
        end
    endtask

    task automatic wait_results(input int target, input int budget);
        int k = 0;
        while (res_count < target && k < budget) begin
            tick();
            k++;
        end
        check("result_count", res_count, target);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || res_valid) && k < budget) begin
            tick();
            k++;
        end
        check("idle", busy, 0);
    endtask

    initial begin
        reset = 1'b0; instr_valid = 1'b0; instr = '0; flush = 1'b0; res_ready = 1'b1;
        repeat (2) tick();
        check("rst_instr_ready", instr_ready, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_issued", issued_count, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        check("post_rst_instr_ready", instr_ready, 1);

        // Single op: window length, result latency, issue count.
        push(mk(0, 1, 2, 4));
        check("t1_no_bypass", alu_control, 0);
        tick();
        check("t1_ctrl_c1", alu_control, 6'b000010);
        check("t1_in1", alu_in1, 2);
        check("t1_in2", alu_in2, 4);
        check("t1_issued", issued_count, 1);
        tick();
        check("t1_ctrl_c2", alu_control, 6'b000010);
        check("t1_res_valid_early", res_valid, 0);
        tick();
        check("t1_res_valid", res_valid, 1);
        check("t1_ctrl_off", alu_control, 0);
        check("t1_in1_hold", alu_in1, 2);
        wait_results(1, 20);

        // Ops 0..5 back to back.
        log_start = ctrl_log.size();
        for (int op = 0; op < 6; op++) push(mk(0, 3'(op), 2, 4));
        wait_results(7, 100);
        wait_idle(20);
        check("t2_log_len", ctrl_log.size() - log_start, 12);
        if (ctrl_log.size() >= log_start + 12) begin
            for (int i = 0; i < 6; i++) begin
                check("t2_ctrl_on", ctrl_log[log_start + 2 * i], 1 << i);
                check("t2_ctrl_gap", ctrl_log[log_start + 2 * i + 1], 0);
            end
        end

        // Mood word.
        push(mk(1, 3, 7, 7));
        tick();
        check("t3_mood", alu_mood, 1);
        check("t3_ctrl", alu_control, 0);
        tick();
        check("t3_mood_c2", alu_mood, 1);
        tick();
        check("t3_mood_off", alu_mood, 0);
        wait_results(8, 20);

        // Illegal opcode followed by a legal one.
        push(mk(0, 6, 1, 1));
        push(mk(0, 0, 3, 5));
        wait_results(9, 30);
        wait_idle(20);
        check("t4_illegal", illegal, 1);
        check("t4_issued", issued_count, exp_issued);
        check("t4_sb_empty", sb.size(), 0);

        // Back-pressure: one in flight plus DEPTH queued, then a long stall.
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(mk(0, 3'(i % 6), 5'(i + 10), 5'(i)));
        check("t5_full", instr_ready, 0);
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        check("t5_res_valid", res_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_stall_data", res_data, sb[0].data);
        end
        check("t5_stall_valid", res_valid, 1);
        res_ready = 1'b1;
        wait_results(14, 100);
        wait_idle(20);
        check("t5_sb_empty", sb.size(), 0);

        // Flush with three words queued and one in DRIVE.
        res_ready = 1'b0;
        push(mk(0, 2, 1, 2));
        push(mk(0, 3, 4, 4));
        push(mk(0, 4, 5, 6));
        push(mk(0, 5, 7, 8));
        push(mk(1, 0, 9, 10));
        n = 0;
        while (!res_valid && n < 20) begin tick(); n++; end
        check("t6_a_valid", res_valid, 1);
        res_ready = 1'b1;
        tick();
        tick();
        check("t6_drive_b", alu_control, 6'b001000);
        flush = 1'b1;
        instr_valid = 1'b1;
        instr = mk(0, 0, 9, 9);
        tick();
        flush = 1'b0;
        instr_valid = 1'b0;
        sb.delete();
        exp_issued -= 3;
        check("t6_alu_reset", alu_reset, 1);
        check("t6_ctrl_clear", alu_control, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", instr_ready, 1);
        tick();
        check("t6_alu_reset_off", alu_reset, 0);
        check("t6_busy_after", busy, 0);
        repeat (6) tick();
        check("t6_no_result", res_count, 15);
        check("t6_res_valid_late", res_valid, 0);
        check("t6_illegal_kept", illegal, 1);
        check("t6_issued_kept", issued_count, exp_issued);

        // Asynchronous reset in the middle of DRIVE.
        push(mk(0, 4, 6, 6));
        tick();
        check("t7_drive", alu_control, 6'b010000);
        reset = 1'b0;
        #1;
        sb.delete();
        exp_issued = 0;
        check("t7_ctrl", alu_control, 0);
        check("t7_mood", alu_mood, 0);
        check("t7_in1", alu_in1, 0);
        check("t7_res_valid", res_valid, 0);
        check("t7_res_data", res_data, 0);
        check("t7_issued", issued_count, 0);
        check("t7_illegal", illegal, 0);
        check("t7_ready", instr_ready, 0);
        check("t7_busy", busy, 0);
        tick();
        reset = 1'b1;
        #1;
        check("t7_ready_release", instr_ready, 1);
        push(mk(0, 5, 3, 3));
        wait_results(16, 20);
        wait_idle(20);
        check("t7_issued_after", issued_count, exp_issued);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
